slug_uart_tx: RTL and testbench

- Serial transmit stage fed directly by the slug CPU's 32-bit output port.
- Accepts bytes through a toggle handshake carried on port_out, buffers them in a small FIFO, and shifts them out as 8N1 UART frames, LSB first.
- Returns a 4-bit status nibble that the top level wires onto one nibble of slug's port_in, so firmware can poll it.

---
 rtl/slug_uart_pkg.sv | 20 ++
 rtl/slug_uart_tx_byte_fifo.sv | 54 +++++
 rtl/slug_uart_tx.sv | 148 ++++++++++++++
 tb/tb_slug_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/slug_uart_pkg.sv
// Shared types and field positions for the slug UART transmit stage.
package slug_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int STAT_ACK  = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_DONE = 2;
  localparam int STAT_BUSY = 3;

  localparam int STB_BIT  = 8;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 8;

endpackage

// File: rtl/slug_uart_tx_byte_fifo.sv
// Small synchronous byte FIFO with a registered occupancy count.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/slug_uart_tx.sv
// 8N1 UART transmitter fed by slug's output port through a toggle handshake,
// with a byte FIFO and a pollable status nibble.
module slug_uart_tx
  import slug_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] port_out,
  output logic [3:0]  status,
  output logic        tx
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  tx_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ack_q, ack_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic        unused_port_bits;

  assign unused_port_bits = ^port_out[31:STB_BIT+1];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (port_out[DATA_LSB +: DATA_W]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A request stays pending while full, so the byte is taken on the first
  // edge with room rather than being dropped.
  always_comb begin
    fifo_push = (port_out[STB_BIT] != ack_q) && !fifo_full;
    ack_d     = fifo_push ? port_out[STB_BIT] : ack_q;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          baud_d   = BAUD_RELOAD;
          state_d  = START;
        end
      end

      START: begin
        if (baud_q == '0) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            baud_d   = BAUD_RELOAD;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    status            = '0;
    status[STAT_ACK]  = ack_q;
    status[STAT_FULL] = fifo_full;
    status[STAT_DONE] = fifo_empty && (state_q == IDLE);
    status[STAT_BUSY] = (state_q != IDLE);
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_slug_uart_tx.sv
// Self-checking bench for slug_uart_tx: frame-level reference model checked
// every cycle, plus table-driven frames and directed corner sequences.
module tb_slug_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LAST_T     = 10 * CLK_DIV - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] port_out = '0;
  logic [3:0]  status;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;
  bit saw_full = 1'b0;

  slug_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_out (port_out),
    .status   (status),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted bytes and a frame timer that runs
  // 0..10*CLK_DIV-1 over the byte currently on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = '0;
  bit         m_ack = 1'b0;
  bit         m_active = 1'b0;
  int         m_t = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ack    = 1'b0;
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      bit pending, was_full, was_empty, do_pop;
      pending   = (port_out[8] != m_ack);
      was_full  = (m_q.size() == FIFO_DEPTH);
      was_empty = (m_q.size() == 0);
      do_pop    = 1'b0;
      if (!m_active) begin
        if (!was_empty) do_pop = 1'b1;
      end else if (m_t == LAST_T) begin
        if (!was_empty) do_pop = 1'b1;
        else m_active = 1'b0;
      end else begin
        m_t = m_t + 1;
      end
      if (do_pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (pending && !was_full) begin
        m_q.push_back(port_out[7:0]);
        m_ack = port_out[8];
      end
    end
  end

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [3:0] model_status();
    logic [3:0] s;
    s[0] = m_ack;
    s[1] = (m_q.size() == FIFO_DEPTH);
    s[2] = (m_q.size() == 0) && !m_active;
    s[3] = m_active;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_tx", {31'b0, tx}, {31'b0, model_tx()});
    checkOutput("model_status", {28'b0, status}, {28'b0, model_status()});
    if (status[1] === 1'b1) saw_full = 1'b1;
  end

  // Toggle the strobe with new data and poll ack like firmware would.
  task automatic applyStimulus(input logic [7:0] data);
    bit got;
    @(negedge clk);
    port_out[7:0] = data;
    port_out[8]   = ~port_out[8];
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (status[0] === port_out[8]) got = 1'b1;
    end
    checkOutput("ack_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic waitDone();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (status[2] === 1'b1 && status[3] === 1'b0) ok = 1'b1;
    end
    checkOutput("done_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic waitModelT(input int t);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (m_active && m_t == t) ok = 1'b0 | 1'b1;
    end
    checkOutput("frame_pos_timeout", {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic [3:0] end_status;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b0101001011, end_status: 4'b0101};
    vecs[1] = '{data: 8'h3C, frame: 10'b0001111001, end_status: 4'b0100};
    vecs[2] = '{data: 8'h01, frame: 10'b0100000001, end_status: 4'b0101};
    vecs[3] = '{data: 8'hFF, frame: 10'b0111111111, end_status: 4'b0100};
    vecs[4] = '{data: 8'h80, frame: 10'b0000000011, end_status: 4'b0101};

    #12;
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    checkOutput("reset_status", {28'b0, status}, 32'h4);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_status", {28'b0, status}, 32'h4);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      port_out[7:0] = vecs[v].data;
      port_out[8]   = ~port_out[8];
      @(negedge clk);
      checkOutput("ack_latency", {31'b0, status[0]}, {31'b0, port_out[8]});
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        checkOutput("frame_bit", {31'b0, tx}, {31'b0, vecs[v].frame[9-k]});
        repeat (CLK_DIV) @(negedge clk);
      end
      checkOutput("frame_end_status", {28'b0, status}, {28'b0, vecs[v].end_status});
    end

    for (int b = 1; b <= 6; b++) applyStimulus(8'(b));
    waitDone();
    checkOutput("saw_full", {31'b0, saw_full}, 32'd1);

    for (int b = 0; b < 5; b++) applyStimulus(8'hC0 + 8'(b));
    @(negedge clk);
    port_out[7:0] = 8'hAA;
    port_out[8]   = ~port_out[8];
    repeat (3) @(negedge clk);
    checkOutput("ack_held_full", {31'b0, status[0]}, {31'b0, ~port_out[8]});
    port_out[7:0] = 8'h55;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (status[0] === port_out[8]) got = 1'b1;
      end
      checkOutput("late_ack_timeout", {31'b0, got}, 32'd1);
    end
    waitDone();

    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    waitModelT(4 * CLK_DIV + 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_tx_immediate", {31'b0, tx}, 32'd1);
    checkOutput("rst_status_immediate", {28'b0, status}, 32'h4);
    port_out = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("post_rst_status", {28'b0, status}, 32'h4);

    applyStimulus(8'h44);
    applyStimulus(8'h66);
    waitModelT(LAST_T);
    port_out[7:0] = 8'h77;
    port_out[8]   = ~port_out[8];
    @(negedge clk);
    checkOutput("pushpop_ack", {31'b0, status[0]}, {31'b0, port_out[8]});
    checkOutput("pushpop_not_done", {31'b0, status[2]}, 32'd0);
    waitDone();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      port_out[31:9] = 23'($urandom);
      applyStimulus(8'($urandom));
    end
    waitDone();
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
